// File: rtl/muldiv_unit_pkg.sv
// Shared constants for the RV32M multiply/divide unit: funct3 codes,
// FSM state encodings and the iteration count.
package muldiv_unit_pkg;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  localparam int MULDIV_STEPS = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } muldiv_state_e;

  // Two's-complement negate when cond is set.
  function automatic logic [31:0] neg32_if(input logic [31:0] val, input logic cond);
    return cond ? (32'd0 - val) : val;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shift-add multiply or the restoring divide.
// Multiply: i_acc is the product high half, i_opnd the multiplier (low half).
// Divide:   i_acc is the partial remainder, i_opnd the dividend/quotient.
module muldiv_step (
  input  logic [31:0] i_acc,
  input  logic [31:0] i_opnd,
  input  logic [31:0] i_divisor,
  input  logic        i_div,
  output logic [31:0] o_acc,
  output logic [31:0] o_opnd
);

  logic [32:0] w_sum;
  logic [32:0] w_shl;
  logic [32:0] w_trial;

  // Compute both candidate iterations and select by mode.
  always_comb begin
    w_sum   = {1'b0, i_acc} + (i_opnd[0] ? {1'b0, i_divisor} : 33'd0);
    w_shl   = {i_acc, i_opnd[31]};
    w_trial = w_shl - {1'b0, i_divisor};
    o_acc   = '0;
    o_opnd  = '0;
    if (i_div) begin
      if (w_shl >= {1'b0, i_divisor}) begin
        o_acc  = w_trial[31:0];
        o_opnd = {i_opnd[30:0], 1'b1};
      end else begin
        o_acc  = w_shl[31:0];
        o_opnd = {i_opnd[30:0], 1'b0};
      end
    end else begin
      // Carry out of the add becomes the new top bit after the right shift.
      o_acc  = w_sum[32:1];
      o_opnd = {w_sum[0], i_opnd[31:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit. Operands are converted to magnitudes
// on accept, processed 32 steps, then sign-fixed into a registered result.
// Optional feature macro: MULDIV_FAST_MUL_EN (single-cycle 33x33 multiply).
// Handshake: iStart is a request sampled only in IDLE; oDone is a one-cycle
// pulse marking oResult valid; oBusy is high from accept until the DONE
// cycle ends; iFlush aborts any state with priority and produces no oDone.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iStart,
  input  logic             iFlush,
  input  logic [2:0]       iFunct3,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  output logic             oBusy,
  output logic             oDone,
  output logic [WIDTH-1:0] oResult,
  output logic [1:0]       oDbgState
);

  muldiv_state_e r_state, w_next_state;
  logic [4:0]  r_count;
  logic [2:0]  r_funct3;
  logic        r_neg_res;
  logic        r_neg_rem;
  logic [31:0] r_acc;
  logic [31:0] r_opnd;
  logic [31:0] r_mcand;
  logic [31:0] r_result;

  logic        w_is_div, w_a_signed, w_b_signed, w_a_neg, w_b_neg;
  logic [31:0] w_a_mag, w_b_mag;
  logic        w_div0, w_ovf, w_skip;
  logic [31:0] w_skip_res;
  logic [31:0] w_step_acc, w_step_opnd;
  logic [63:0] w_prod;
  logic [31:0] w_final;

  muldiv_step u_step (
    .i_acc     (r_acc),
    .i_opnd    (r_opnd),
    .i_divisor (r_mcand),
    .i_div     (r_funct3[2]),
    .o_acc     (w_step_acc),
    .o_opnd    (w_step_opnd)
  );

  // Operand decode: signedness, magnitudes and the no-iteration special cases.
  always_comb begin
    w_is_div   = iFunct3[2];
    w_a_signed = (iFunct3 == MD_MULH) || (iFunct3 == MD_MULHSU) ||
                 (iFunct3 == MD_DIV)  || (iFunct3 == MD_REM);
    w_b_signed = (iFunct3 == MD_MULH) || (iFunct3 == MD_DIV) || (iFunct3 == MD_REM);
    w_a_neg    = w_a_signed & iA[31];
    w_b_neg    = w_b_signed & iB[31];
    w_a_mag    = neg32_if(iA, w_a_neg);
    w_b_mag    = neg32_if(iB, w_b_neg);
    w_div0     = w_is_div && (iB == 32'd0);
    w_ovf      = ((iFunct3 == MD_DIV) || (iFunct3 == MD_REM)) &&
                 (iA == 32'h8000_0000) && (iB == 32'hFFFF_FFFF);
    w_skip     = w_div0 | w_ovf;
    w_skip_res = '0;
    if (w_div0) begin
      w_skip_res = iFunct3[1] ? iA : 32'hFFFF_FFFF;
    end else if (w_ovf) begin
      w_skip_res = iFunct3[1] ? 32'd0 : 32'h8000_0000;
    end
`ifdef MULDIV_FAST_MUL_EN
    if (!w_is_div) begin
      w_skip     = 1'b1;
      w_skip_res = fast_mul(iA, iB, w_a_signed, w_b_signed, iFunct3 == MD_MUL);
    end
`endif
  end

`ifdef MULDIV_FAST_MUL_EN
  // Single-cycle product; sign-extend to 33 bits so one signed multiplier
  // covers signed, mixed and unsigned operand pairs.
  function automatic logic [31:0] fast_mul(input logic [31:0] a, input logic [31:0] b,
                                           input logic sa, input logic sb, input logic lo);
    logic signed [65:0] p;
    p = 66'(signed'({sa & a[31], a})) * 66'(signed'({sb & b[31], b}));
    return lo ? p[31:0] : p[63:32];
  endfunction
`endif

  // Sign fix of the final iteration's outputs and result selection.
  always_comb begin
    w_prod  = neg64_if({w_step_acc, w_step_opnd}, r_neg_res);
    w_final = '0;
    case (r_funct3)
      MD_MUL:                     w_final = w_prod[31:0];
      MD_MULH, MD_MULHSU, MD_MULHU: w_final = w_prod[63:32];
      MD_DIV, MD_DIVU:            w_final = neg32_if(w_step_opnd, r_neg_res);
      default:                    w_final = neg32_if(w_step_acc, r_neg_rem);
    endcase
  end

  function automatic logic [63:0] neg64_if(input logic [63:0] val, input logic cond);
    return cond ? (64'd0 - val) : val;
  endfunction

  // FSM state register.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // FSM next-state logic; flush wins over start and over the counter.
  always_comb begin
    w_next_state = r_state;
    if (iFlush) begin
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (iStart) w_next_state = w_skip ? ST_DONE : ST_CALC;
        ST_CALC: if (r_count == 5'd0) w_next_state = ST_DONE;
        default: w_next_state = ST_IDLE;
      endcase
    end
  end

  // Datapath: operand latch on accept, one iteration per CALC cycle,
  // result capture on the way into DONE.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_count   <= '0;
      r_funct3  <= '0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_acc     <= '0;
      r_opnd    <= '0;
      r_mcand   <= '0;
      r_result  <= '0;
    end else if (iFlush) begin
      r_count <= '0;
    end else if (r_state == ST_IDLE && iStart) begin
      r_funct3  <= iFunct3;
      r_neg_res <= w_a_neg ^ w_b_neg;
      r_neg_rem <= w_a_neg;
      r_acc     <= '0;
      r_opnd    <= w_is_div ? w_a_mag : w_b_mag;
      r_mcand   <= w_is_div ? w_b_mag : w_a_mag;
      r_count   <= 5'(MULDIV_STEPS - 1);
      if (w_skip) r_result <= w_skip_res;
    end else if (r_state == ST_CALC) begin
      r_acc   <= w_step_acc;
      r_opnd  <= w_step_opnd;
      r_count <= r_count - 5'd1;
      if (r_count == 5'd0) r_result <= w_final;
    end
  end

  assign oBusy     = (r_state != ST_IDLE);
  assign oDone     = (r_state == ST_DONE);
  assign oResult   = r_result;
  assign oDbgState = r_state;

endmodule
